axi_lite_manager: RTL and testbench
===================================

# axi_lite_manager

Single-outstanding AXI4-Lite manager that turns a simple command/response handshake into AXI write (AW/W/B) and read (AR/R) transactions. It sits directly upstream of `axi_subordinate`, driving the manager side of an `axi4_if` instance, and replaces task-driven stimulus with synthesizable RTL. It adds a response timeout and rejects mismatched IDs.

## Interface
- ADDR_W, 32, address width; must match the connected `axi4_if`
- DATA_W, 64, data width; must match `axi4_if`; power of two ≥ 32
- ID_W, 4, ID width; must match `axi4_if`
- TIMEOUT, 256, max cycles waiting for B/R; 0 disables timeout

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset ARESETn, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_id  in  ID_W  transaction ID
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_write  out  1  echo of cmd_write
- rsp_id  out  ID_W  echo of cmd_id
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- err_cnt  out  8  saturating count of discarded ID-mismatched B/R beats
- m  interface  —  `axi4_if.manager_mp`

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On handshake, all cmd fields are registered. cmd_write=1 goes to WR_REQ, else RD_REQ.
- WR_REQ: AWVALID and WVALID assert together. AWLEN=0, AWSIZE=log2(DATA_W/8), AWBURST=INCR, WLAST=1.
  - Flags aw_done and w_done are set independently on each handshake, and each VALID drops after its own handshake.
  - Go to WR_RESP when both flags are set (same-cycle handshakes allowed).
- WR_RESP: BREADY=1.
  - BVALID with BID==id: capture BRESP, go to RSP.
  - BVALID with BID≠id: consume the beat, err_cnt++, stay.
- RD_REQ: ARVALID=1 with ARLEN=0 and same size/burst as writes. On ARREADY go to RD_RESP.
- RD_RESP: RREADY=1.
  - RVALID with RID==id: capture RDATA and RRESP, go to RSP. RLAST is not checked.
  - RVALID with RID≠id: discard the beat, err_cnt++.
- Timeout: a counter clears on entry to WR_RESP/RD_RESP and increments each cycle without a matching beat.
  - When it reaches TIMEOUT: rsp_resp=2'b10, rsp_rdata=0, go to RSP.
  - Request phases never time out.
- RSP: rsp_valid=1, all rsp_* fields stable until rsp_ready, then IDLE.
- err_cnt saturates at 8'hFF.
- VALIDs are never withdrawn before their handshake (AXI rule).

## Timing
- Reset (ARESETn=1, async) forces:
  - state=IDLE
  - cmd_ready=0 while in reset, 1 on the first cycle after release
  - all AXI VALID/READY outputs=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_id=0, rsp_write=0, err_cnt=0, timeout counter=0
- Reset mid-transaction: outputs return to the reset values immediately. No response is produced for the aborted command.
- All AXI and rsp outputs are registered.
- Command handshake at cycle T: AWVALID/WVALID or ARVALID high at T+1.
- Zero-wait subordinate: handshake at T+1, BREADY/RREADY high at T+2, matching beat at T+2, rsp_valid at T+3. Minimum latency is 3 cycles.
- rsp_ready high in the same cycle rsp_valid rises: RSP lasts 1 cycle and cmd_ready returns the next cycle. Back-to-back commands therefore take 4 cycles each.
- Exactly one transaction is outstanding at a time. cmd_ready is 0 outside IDLE.

## Test plan
- Write 64'hABCD_EF12_3456_7890 (id 1, addr 32'h20, wstrb 8'hFF), then read id 1, addr 32'h20 -> write rsp_resp=0; read rsp_rdata=64'hABCD_EF12_3456_7890, rsp_id=1.
- AWREADY held low 5 cycles while WREADY=1 immediately -> WVALID drops after 1 cycle, AWVALID holds 6 cycles, a single B is accepted, rsp_valid rises.
- Read with the subordinate never asserting RVALID, TIMEOUT=16 -> rsp_valid 16 cycles after RREADY rises, rsp_resp=2'b10, rsp_rdata=0.
- Read id 3; stub returns RID=5 then RID=3 with data 64'h1234 -> err_cnt=1, rsp_rdata=64'h1234, rsp_id=3.
- ARESETn pulsed during WR_RESP -> all VALID/READY outputs 0, no rsp_valid; a following write to 32'h20 completes normally.
- Two writes with rsp_ready held low 10 cycles after the first -> rsp fields stable throughout, cmd_ready=0 until rsp_ready, second write then completes.

Source files
------------

// File: rtl/axi_lite_manager_if.sv
// AXI4-Lite channel bundle shared by a manager and a subordinate.
// Burst fields are carried so the bundle also fits full AXI4 peers.
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic                awvalid, awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                wvalid, wready, wlast;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid, bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                arvalid, arready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                rvalid, rready, rlast;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport manager_mp (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport subordinate_mp (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_lite_manager.sv
// Single-outstanding AXI4-Lite manager: one command in, one AXI transaction
// out, one response back, with response timeout and ID-mismatch filtering.
module axi_lite_manager #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [7:0]          err_cnt,
    axi4_if.manager_mp          m
);
    localparam int STRB_W = DATA_W / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    state_t              state;
    logic                write_q, aw_done, w_done;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic [TW-1:0]       tmo_cnt;

    logic                aw_hs, w_hs, resp_hit, resp_bad, tmo_hit;
    logic [1:0]          hit_resp;
    logic [DATA_W-1:0]   hit_data;
    logic                unused_ok;

    assign aw_hs    = awvalid_q && m.awready;
    assign w_hs     = wvalid_q && m.wready;
    // Only the channel belonging to the current transaction is ever READY.
    assign resp_hit = write_q ? (m.bvalid && m.bid == id_q) : (m.rvalid && m.rid == id_q);
    assign resp_bad = write_q ? (m.bvalid && m.bid != id_q) : (m.rvalid && m.rid != id_q);
    assign hit_resp = write_q ? m.bresp : m.rresp;
    assign hit_data = write_q ? '0 : m.rdata;
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign unused_ok = m.rlast;

    assign m.awvalid = awvalid_q;
    assign m.awid    = id_q;
    assign m.awaddr  = addr_q;
    assign m.awlen   = 8'd0;
    assign m.awsize  = AXSIZE;
    assign m.awburst = 2'b01;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.wlast   = 1'b1;
    assign m.bready  = bready_q;
    assign m.arvalid = arvalid_q;
    assign m.arid    = id_q;
    assign m.araddr  = addr_q;
    assign m.arlen   = 8'd0;
    assign m.arsize  = AXSIZE;
    assign m.arburst = 2'b01;
    assign m.rready  = rready_q;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            write_q   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_cnt   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        write_q   <= cmd_write;
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        if (cmd_write) begin
                            state     <= WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= RD_REQ;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state    <= WR_RESP;
                        bready_q <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                end
                RD_REQ: begin
                    if (m.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= RD_RESP;
                    end
                end
                WR_RESP, RD_RESP: begin
                    if (resp_bad && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                    if (resp_hit || tmo_hit) begin
                        state     <= RSP;
                        bready_q  <= 1'b0;
                        rready_q  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= write_q;
                        rsp_id    <= id_q;
                        rsp_resp  <= resp_hit ? hit_resp : 2'b10;
                        rsp_rdata <= resp_hit ? hit_data : '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_manager.sv
// Bench for axi_lite_manager: directed commands against a small AXI memory
// stub, responses checked by a queue-based scoreboard.
module tb_axi_lite_manager;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_ready = 1'b1;
    logic        cmd_ready, rsp_valid, rsp_write;
    logic [3:0]  rsp_id;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;

    always #5 ACLK = ~ACLK;

    axi4_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus();

    axi_lite_manager #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .err_cnt(err_cnt), .m(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w;
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Subordinate stub: zero-wait memory with knobs for stalls and faults.
    logic        aw_block = 1'b0, b_hold = 1'b0, r_never = 1'b0, r_bad_en = 1'b0;
    logic [63:0] mem [0:63];
    logic        aw_got, w_got, r_good_pend;
    logic [31:0] aw_addr_s, r_addr_s;
    logic [3:0]  aw_id_s, r_id_s;
    logic [63:0] w_data_s;
    logic [7:0]  w_strb_s;
    int          b_cnt = 0;
    logic        s_aw_hs, s_w_hs;
    logic [31:0] wa;
    logic [3:0]  wid;
    logic [63:0] wd;
    logic [7:0]  ws;

    assign bus.awready = !aw_block;
    assign bus.wready  = 1'b1;
    assign bus.arready = 1'b1;
    assign s_aw_hs = bus.awvalid && bus.awready;
    assign s_w_hs  = bus.wvalid && bus.wready;
    assign wa  = s_aw_hs ? bus.awaddr : aw_addr_s;
    assign wid = s_aw_hs ? bus.awid : aw_id_s;
    assign wd  = s_w_hs ? bus.wdata : w_data_s;
    assign ws  = s_w_hs ? bus.wstrb : w_strb_s;

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            aw_got <= 1'b0; w_got <= 1'b0; r_good_pend <= 1'b0;
            bus.bvalid <= 1'b0; bus.bid <= '0; bus.bresp <= '0;
            bus.rvalid <= 1'b0; bus.rid <= '0; bus.rdata <= '0; bus.rresp <= '0; bus.rlast <= 1'b0;
        end else begin
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                b_cnt <= b_cnt + 1;
            end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !b_hold && !bus.bvalid) begin
                bus.bvalid <= 1'b1;
                bus.bid <= wid;
                bus.bresp <= 2'b00;
                mem[wa[8:3]] <= merge(mem[wa[8:3]], wd, ws);
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end else begin
                if (s_aw_hs) begin aw_got <= 1'b1; aw_addr_s <= bus.awaddr; aw_id_s <= bus.awid; end
                if (s_w_hs) begin w_got <= 1'b1; w_data_s <= bus.wdata; w_strb_s <= bus.wstrb; end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (bus.arvalid && bus.arready && !r_never) begin
                bus.rvalid <= 1'b1; bus.rresp <= 2'b00; bus.rlast <= 1'b1;
                if (r_bad_en) begin
                    bus.rid <= 4'd5; bus.rdata <= 64'hDEAD_BEEF;
                    r_good_pend <= 1'b1; r_id_s <= bus.arid; r_addr_s <= bus.araddr;
                end else begin
                    bus.rid <= bus.arid; bus.rdata <= mem[bus.araddr[8:3]];
                end
            end else if (r_good_pend && bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b1; bus.rid <= r_id_s; bus.rdata <= mem[r_addr_s[8:3]];
                r_good_pend <= 1'b0;
            end
        end
    end

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge ACLK) begin
        exp_t e;
        if (!ARESETn && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected actual id=%0d expected=none", rsp_id);
            end else begin
                e = expq.pop_front();
                chk("rsp_write", rsp_write, e.w);
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_rdata", rsp_rdata, e.data);
                chk("rsp_resp", rsp_resp, e.resp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic expect_rsp(input logic w, input logic [3:0] id, input logic [63:0] d, input logic [1:0] r);
        exp_t e;
        e.w = w; e.id = id; e.data = d; e.resp = r;
        expq.push_back(e);
    endtask

    // Returns #1 after the accepting edge, i.e. in cycle T+1.
    task automatic send(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                        input logic [63:0] wdat, input logic [7:0] strb);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
        cmd_wdata = wdat; cmd_wstrb = strb;
        while (!cmd_ready && n < 100) begin tick(1); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout actual=0 expected=1");
        end
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || !cmd_ready) && n < 200) begin tick(1); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", expq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int awn, wn, n, bstart;
        logic [70:0] snap;
        logic stable, rdy_seen;

        tick(3);
        chk("reset_handshakes", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, cmd_ready}, 0);
        chk("reset_rsp_fields", {rsp_write, rsp_id, rsp_resp}, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_err_cnt", err_cnt, 0);
        ARESETn = 1'b0;
        tick(1);
        chk("ready_after_reset", cmd_ready, 1);

        // Zero-wait write then read-back, with cycle-exact latency.
        expect_rsp(1'b1, 4'd1, 64'd0, 2'b00);
        send(1'b1, 4'd1, 32'h20, 64'hABCD_EF12_3456_7890, 8'hFF);
        chk("aw_w_valid_T1", {bus.awvalid, bus.wvalid}, 2'b11);
        chk("aw_attrs", {bus.awlen, bus.awsize, bus.awburst, bus.wlast}, {8'd0, 3'd3, 2'b01, 1'b1});
        tick(1);
        chk("bready_T2", bus.bready, 1);
        tick(1);
        chk("rsp_valid_T3", rsp_valid, 1);
        tick(1);
        chk("cmd_ready_T4", cmd_ready, 1);
        expect_rsp(1'b0, 4'd1, 64'hABCD_EF12_3456_7890, 2'b00);
        send(1'b0, 4'd1, 32'h20, 64'd0, 8'h00);
        chk("ar_attrs", {bus.arvalid, bus.arlen, bus.arsize, bus.arburst}, {1'b1, 8'd0, 3'd3, 2'b01});
        drain();

        // AWREADY stalled 5 cycles, WREADY immediate.
        aw_block = 1'b1;
        bstart = b_cnt;
        expect_rsp(1'b1, 4'd2, 64'd0, 2'b00);
        send(1'b1, 4'd2, 32'h28, 64'h1111_2222_3333_4444, 8'hFF);
        awn = 0; wn = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick(1);
            if (k == 5) aw_block = 1'b0;
            awn += int'(bus.awvalid);
            wn  += int'(bus.wvalid);
        end
        chk("awvalid_cycles", awn, 6);
        chk("wvalid_cycles", wn, 1);
        drain();
        chk("b_beats", b_cnt - bstart, 1);

        // Read that never gets RVALID.
        r_never = 1'b1;
        expect_rsp(1'b0, 4'd2, 64'd0, 2'b10);
        send(1'b0, 4'd2, 32'h28, 64'd0, 8'h00);
        tick(1);
        chk("rready_up", bus.rready, 1);
        n = 0;
        while (!rsp_valid && n < 40) begin tick(1); n++; end
        chk("timeout_cycles", n, 16);
        drain();
        r_never = 1'b0;

        // Mismatched RID beat ahead of the real one.
        expect_rsp(1'b1, 4'd3, 64'd0, 2'b00);
        send(1'b1, 4'd3, 32'h40, 64'h1234, 8'hFF);
        drain();
        r_bad_en = 1'b1;
        expect_rsp(1'b0, 4'd3, 64'h1234, 2'b00);
        send(1'b0, 4'd3, 32'h40, 64'd0, 8'h00);
        drain();
        r_bad_en = 1'b0;
        chk("err_cnt_bad_id", err_cnt, 1);

        // Reset while waiting for B: the aborted write produces no response.
        b_hold = 1'b1;
        send(1'b1, 4'd4, 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        tick(2);
        chk("in_wr_resp", bus.bready, 1);
        ARESETn = 1'b1;
        #1;
        chk("abort_outputs", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, cmd_ready}, 0);
        chk("abort_err_cnt", err_cnt, 0);
        b_hold = 1'b0;
        tick(2);
        ARESETn = 1'b0;
        tick(1);
        chk("ready_after_abort", cmd_ready, 1);
        expect_rsp(1'b1, 4'd4, 64'd0, 2'b00);
        send(1'b1, 4'd4, 32'h20, 64'h5555_AAAA_0000_FFFF, 8'h0F);
        drain();
        expect_rsp(1'b0, 4'd4, 64'hABCD_EF12_0000_FFFF, 2'b00);
        send(1'b0, 4'd4, 32'h20, 64'd0, 8'h00);
        drain();

        // Response back-pressure with a second command waiting.
        rsp_ready = 1'b0;
        expect_rsp(1'b1, 4'd6, 64'd0, 2'b00);
        send(1'b1, 4'd6, 32'h60, 64'h6666, 8'hFF);
        n = 0;
        while (!rsp_valid && n < 20) begin tick(1); n++; end
        chk("held_rsp_valid", rsp_valid, 1);
        snap = {rsp_write, rsp_id, rsp_resp, rsp_rdata};
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd7; cmd_addr = 32'h68;
        cmd_wdata = 64'h7777; cmd_wstrb = 8'hFF;
        stable = 1'b1; rdy_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if ({rsp_write, rsp_id, rsp_resp, rsp_rdata} !== snap || !rsp_valid) stable = 1'b0;
            if (cmd_ready) rdy_seen = 1'b1;
        end
        chk("rsp_stable", stable, 1);
        chk("cmd_ready_blocked", rdy_seen, 0);
        expect_rsp(1'b1, 4'd7, 64'd0, 2'b00);
        rsp_ready = 1'b1;
        send(1'b1, 4'd7, 32'h68, 64'h7777, 8'hFF);
        drain();
        expect_rsp(1'b0, 4'd7, 64'h7777, 2'b00);
        send(1'b0, 4'd7, 32'h68, 64'd0, 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
